matrix_scan_ctrl: RTL and testbench

- Row-scan scheduler for the 8x8 RGB LED matrix.
- Owns a double-buffered frame store. The game/move logic writes rows into the back buffer. The scan engine reads the front buffer one row at a time and drives comm/data_r/data_g/data_b.
- Buffers swap only at frame boundaries, so the display never tears mid-frame.
- Replaces the free-running row counter in the game top level; sits between game logic and the matrix pins.

---
 rtl/matrix_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_scan_ctrl
// Brief    : Row-scan scheduler for an 8x8 RGB LED matrix with a double-
//            buffered frame store; optional PWM dimming via MATRIX_SCAN_PWM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl #(
    parameter int DWELL = 10000,
    parameter int BLANK = 16,
    parameter int ROWS  = 8
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_b,
    input  logic       swap_req,
`ifdef MATRIX_SCAN_PWM_EN
    input  logic [2:0] bright,
`endif
    output logic       swap_ack,
    output logic       frame_start,
    output logic [3:0] comm,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b
);

    localparam int C_CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW     = $clog2(C_CMAX + 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_row;
    logic          r_first;
    logic          r_front;
    logic          r_pending;
    // Entry {buffer, row} holds {red, green, blue}
    logic [23:0]   r_mem [0:15];

    logic          w_drive_done;
    logic          w_blank_done;
    logic          w_enter_blank;
    logic [2:0]    w_next_row;
    logic          w_swap;
    logic [23:0]   w_rd;
    logic          w_show;

    assign w_drive_done  = (r_state == ST_DRIVE) && (r_cnt == CW'(DWELL - 1));
    assign w_blank_done  = (r_state == ST_BLANK) && (r_cnt == CW'(BLANK - 1));
    // r_first makes the first edge after reset release open row 0 BLANK
    assign w_enter_blank = r_first || w_drive_done;
    assign w_next_row    = (r_first || (r_row == 3'(ROWS - 1))) ? 3'd0 : r_row + 3'd1;
    assign w_swap        = w_enter_blank && (w_next_row == 3'd0) && r_pending;
    assign w_rd          = r_mem[{r_front, r_row}];

`ifdef MATRIX_SCAN_PWM_EN
    logic [2:0] r_bright;
    int         w_on;

    always_comb begin
        w_on = ((int'(r_bright) + 1) * DWELL) / 8;
        if (w_on < 1) begin
            w_on = 1;
        end
        w_show = (int'(r_cnt) + 1) < w_on;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_bright <= 3'd0;
        end else if (w_enter_blank) begin
            r_bright <= bright;
        end
    end
`else
    assign w_show = 1'b1;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_row       <= 3'd0;
            r_first     <= 1'b1;
            r_front     <= 1'b0;
            r_pending   <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            comm        <= 4'b1000;
            data_r      <= 8'hFF;
            data_g      <= 8'hFF;
            data_b      <= 8'hFF;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 24'hFFFFFF;
            end
        end else begin
            swap_ack    <= w_swap;
            frame_start <= w_enter_blank && (w_next_row == 3'd0);

            // Back buffer is selected by the pre-swap front, so a write on the
            // swap edge lands in the buffer that becomes visible this frame.
            if (wr_en) begin
                r_mem[{~r_front, wr_row}] <= {wr_r, wr_g, wr_b};
            end

            if (w_swap) begin
                r_front   <= ~r_front;
                r_pending <= swap_req;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end

            if (w_enter_blank) begin
                r_first <= 1'b0;
                r_state <= ST_BLANK;
                r_cnt   <= '0;
                r_row   <= w_next_row;
                comm    <= {1'b1, w_next_row};
                data_r  <= 8'hFF;
                data_g  <= 8'hFF;
                data_b  <= 8'hFF;
            end else if (w_blank_done) begin
                r_state <= ST_DRIVE;
                r_cnt   <= '0;
                data_r  <= w_rd[23:16];
                data_g  <= w_rd[15:8];
                data_b  <= w_rd[7:0];
            end else if (r_state == ST_DRIVE) begin
                r_cnt  <= r_cnt + 1'b1;
                data_r <= w_show ? w_rd[23:16] : 8'hFF;
                data_g <= w_show ? w_rd[15:8]  : 8'hFF;
                data_b <= w_show ? w_rd[7:0]   : 8'hFF;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_ctrl
// Brief    : Scoreboard bench for matrix_scan_ctrl against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int ROWS  = 8;
    localparam int RP    = DWELL + BLANK;
    localparam int FRAME = ROWS * RP;

    logic       clk      = 1'b0;
    logic       clear_n  = 1'b1;
    logic       wr_en    = 1'b0;
    logic [2:0] wr_row   = 3'd0;
    logic [7:0] wr_g     = 8'hFF;
    logic [7:0] wr_r     = 8'hFF;
    logic [7:0] wr_b     = 8'hFF;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [3:0] comm;
    logic [7:0] data_r;
    logic [7:0] data_g;
    logic [7:0] data_b;
`ifdef MATRIX_SCAN_PWM_EN
    logic [2:0] bright = 3'd7;
`endif

    matrix_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .ROWS(ROWS)) u_dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_g        (wr_g),
        .wr_r        (wr_r),
        .wr_b        (wr_b),
        .swap_req    (swap_req),
`ifdef MATRIX_SCAN_PWM_EN
        .bright      (bright),
`endif
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .comm        (comm),
        .data_r      (data_r),
        .data_g      (data_g),
        .data_b      (data_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] comm;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       fs;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_seen = 0;

    // Frame-level model: two buffers, a front select, a pending flag and the
    // edge count since reset release, from which row and phase follow.
    logic [23:0] m_buf [2][8];
    int          m_front;
    bit          m_pend;
    int          m_n;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                m_buf[b][r] = 24'hFFFFFF;
        m_front = 0;
        m_pend  = 1'b0;
        m_n     = 0;
    endtask

    function automatic int next_p();
        return m_n % FRAME;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit we, input int row, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit sreq);
        exp_t e;
        int   p, rw, ph;
        @(negedge clk);
        wr_en = we; wr_row = 3'(row); wr_r = r; wr_g = g; wr_b = b; swap_req = sreq;
        m_n++;
        p     = (m_n - 1) % FRAME;
        e.fs  = (p == 0);
        e.ack = (p == 0) && m_pend;
        if (we) m_buf[1 - m_front][row] = {r, g, b};
        if (p == 0 && m_pend) begin
            m_front = 1 - m_front;
            m_pend  = sreq;
        end else if (sreq) begin
            m_pend = 1'b1;
        end
        rw     = p / RP;
        ph     = p % RP;
        e.comm = {1'b1, 3'(rw)};
        if (ph < BLANK) {e.r, e.g, e.b} = 24'hFFFFFF;
        else            {e.r, e.g, e.b} = m_buf[m_front][rw];
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 8'hFF, 8'hFF, 8'hFF, 0);
    endtask

    task automatic idle_until(input int p);
        for (int i = 0; i < FRAME && next_p() != p; i++) idle(1);
    endtask

    task automatic chk_blank_out(input string tag);
        chk({tag, "_comm"}, 32'(comm), 32'h8);
        chk({tag, "_data"}, {8'h0, data_r, data_g, data_b}, 32'hFFFFFF);
        chk({tag, "_fs_ack"}, {30'h0, frame_start, swap_ack}, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (clear_n && swap_ack) ack_seen++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("scan_out", {2'b0, comm, data_r, data_g, data_b, frame_start, swap_ack},
                    {2'b0, e});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        #2 clear_n = 1'b0;
        #1 chk_blank_out("reset");
        repeat (3) @(posedge clk);
        #2 clear_n = 1'b1;

        // Idle scan: comm walks 8..F, data stays off, frame_start every frame
        idle(2 * FRAME);

        // Back-buffer write is invisible until a swap
        cyc(1, 3, 8'hFF, 8'hFE, 8'hFF, 0);
        idle(2 * FRAME);

        // Single mid-frame swap request
        idle_until(20);
        cyc(0, 0, 8'hFF, 8'hFF, 8'hFF, 1);
        idle(2 * FRAME);

        // Write on the exact swap edge lands in the new front buffer
        idle_until(20);
        cyc(0, 0, 8'hFF, 8'hFF, 8'hFF, 1);
        idle_until(0);
        cyc(1, 0, 8'h7F, 8'hFF, 8'hFF, 0);
        idle(2 * FRAME);

        // swap_req held across three frame boundaries' worth of requests
        idle_until(10);
        ack_seen = 0;
        for (int i = 0; i < 100; i++) cyc(0, 0, 8'hFF, 8'hFF, 8'hFF, 1);
        idle(FRAME);
        chk("held_swap_count", 32'(ack_seen), 32'd3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), 8'($urandom),
                8'($urandom), 8'($urandom), $urandom_range(0, 29) == 0);

        // Reset in the middle of row 5 DRIVE with a swap pending
        for (int r = 0; r < 8; r++) cyc(1, r, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        idle_until(15);
        cyc(0, 0, 8'hFF, 8'hFF, 8'hFF, 1);
        idle_until(27);
        idle(1);
        @(posedge clk);
        #2 clear_n = 1'b0;
        #1 chk_blank_out("mid_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #2 clear_n = 1'b1;
        ack_seen = 0;
        idle(2 * FRAME);
        chk("no_swap_after_reset", 32'(ack_seen), 32'd0);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), 8'($urandom),
                8'($urandom), 8'($urandom), $urandom_range(0, 29) == 0);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
